cond_unit: RTL and testbench

- Consumer end of the ALU flag interface. Holds the architectural NZCV register and evaluates each E-stage instruction's 4-bit ARM condition field against it.
- Gates the write-enables (PCSrc/RegWrite/MemWrite) of the E-stage instruction and commits new ALUFlags when that instruction executes.
- Drives the registered carry back to the ALU for ADC/shifter use, and registers the gated enables into the M stage with stall/flush handling.

---
 rtl/cond_unit_pkg.sv | 57 +++++
 rtl/cond_check.sv | 41 ++++
 rtl/cond_unit.sv | 78 +++++++
 tb/tb_cond_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_unit_pkg.sv
// Shared definitions for the condition unit: ARM condition codes,
// NZCV bit positions, flag-write masks and the E->M enable bundle.
package cond_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] FLAGW_NZ = 2'b10;
    localparam logic [1:0] FLAGW_CV = 2'b01;

    typedef struct packed {
        logic pc_src;
        logic reg_write;
        logic mem_write;
    } em_t;

    localparam em_t EM_BUBBLE = '{pc_src: 1'b0, reg_write: 1'b0, mem_write: 1'b0};

    // Fields whose write-enable is clear keep their old value.
    function automatic logic [3:0] merge_flags(
        input logic [3:0] old_flags,
        input logic [3:0] alu_flags,
        input logic [1:0] flag_w
    );
        logic [3:0] nf;
        nf = old_flags;
        if ((flag_w & FLAGW_NZ) != 2'b00) begin
            nf[FLAG_N] = alu_flags[FLAG_N];
            nf[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if ((flag_w & FLAGW_CV) != 2'b00) begin
            nf[FLAG_C] = alu_flags[FLAG_C];
            nf[FLAG_V] = alu_flags[FLAG_V];
        end
        return nf;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: Cond x NZCV -> pass/fail.
// Kept standalone so a branch predictor can reuse it.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            // NV is unpredictable architecturally; treat as always
            COND_NV: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: holds NZCV, gates E-stage write enables on the
// condition result and registers them into M with stall/flush.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       ValidE,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       StallE,
    input  logic       FlushE,
    output logic       CondEx,
    output logic       PCSrcE,
    output logic [3:0] Flags,
    output logic       C_Flag,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemWriteM
);

    logic [3:0] flags_q;
    logic       exec_e;
    logic       commit;
    em_t        em_d;
    em_t        em_q;

    // Decode sees only the committed flags, never this cycle's ALU result.
    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (CondEx)
    );

    assign exec_e = ValidE & CondEx & ~FlushE;
    assign commit = exec_e & ~StallE;

    always_comb begin
        em_d           = EM_BUBBLE;
        em_d.pc_src    = PCS & exec_e;
        em_d.reg_write = RegW & ~NoWrite & exec_e;
        em_d.mem_write = MemW & exec_e;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            flags_q <= RESET_FLAGS;
        end else if (commit) begin
            flags_q <= merge_flags(flags_q, ALUFlags, FlagW);
        end
    end

    // A stalled or flushed E stage sends a bubble into M.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            em_q <= EM_BUBBLE;
        end else if (FlushE || StallE) begin
            em_q <= EM_BUBBLE;
        end else begin
            em_q <= em_d;
        end
    end

    assign PCSrcE    = em_d.pc_src;
    assign Flags     = flags_q;
    assign C_Flag    = flags_q[FLAG_C];
    assign PCSrcM    = em_q.pc_src;
    assign RegWriteM = em_q.reg_write;
    assign MemWriteM = em_q.mem_write;

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit.
module tb_cond_unit;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic       ValidE;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite;
    logic       StallE, FlushE;
    logic       CondEx, PCSrcE;
    logic [3:0] Flags;
    logic       C_Flag;
    logic       PCSrcM, RegWriteM, MemWriteM;

    int n_run  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    cond_unit #(.RESET_FLAGS(4'b0000)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .ValidE    (ValidE),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .NoWrite   (NoWrite),
        .StallE    (StallE),
        .FlushE    (FlushE),
        .CondEx    (CondEx),
        .PCSrcE    (PCSrcE),
        .Flags     (Flags),
        .C_Flag    (C_Flag),
        .PCSrcM    (PCSrcM),
        .RegWriteM (RegWriteM),
        .MemWriteM (MemWriteM)
    );

    function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ValidE = 0; Cond = 4'b1110; ALUFlags = 0; FlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
        StallE = 0; FlushE = 0;
    endtask

    task automatic load_flags(input logic [3:0] v);
        idle();
        ValidE = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = v;
        tick();
        idle();
        #1;
    endtask

    task automatic test_reset();
        idle();
        RESETn = 0;
        #2;
        n_run++;
        if (Flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=0000", Flags);
        end
        n_run++;
        if ({PCSrcM, RegWriteM, MemWriteM} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_m got=%b exp=000", {PCSrcM, RegWriteM, MemWriteM});
        end
        tick();
        RESETn = 1;
        tick();
        ValidE = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1010;
        PCS = 1; RegW = 1; MemW = 1;
        tick();
        n_run++;
        if ({Flags, PCSrcM, RegWriteM, MemWriteM} !== 7'b1010_111) begin
            n_fail++;
            $display("FAIL pre_reset_state got=%b exp=1010111",
                     {Flags, PCSrcM, RegWriteM, MemWriteM});
        end
        StallE = 1;
        #2;
        RESETn = 0;
        #1;
        n_run++;
        if ({Flags, PCSrcM, RegWriteM, MemWriteM} !== 7'b0000_000) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=0000000",
                     {Flags, PCSrcM, RegWriteM, MemWriteM});
        end
        idle();
        tick();
        RESETn = 1;
        tick();
    endtask

    task automatic test_cmp_beq();
        idle();
        ValidE = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110;
        NoWrite = 1; RegW = 1;
        #1;
        n_run++;
        if (CondEx !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp_condex got=%b exp=1", CondEx);
        end
        tick();
        n_run++;
        if (RegWriteM !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_nowrite got=%b exp=0", RegWriteM);
        end
        n_run++;
        if (Flags !== 4'b0110) begin
            n_fail++;
            $display("FAIL cmp_flags got=%b exp=0110", Flags);
        end
        idle();
        ValidE = 1; Cond = 4'b0000; PCS = 1;
        #1;
        n_run++;
        if (PCSrcE !== 1'b1) begin
            n_fail++;
            $display("FAIL beq_pcsrce got=%b exp=1", PCSrcE);
        end
        tick();
        n_run++;
        if (PCSrcM !== 1'b1) begin
            n_fail++;
            $display("FAIL beq_pcsrcm got=%b exp=1", PCSrcM);
        end
        idle();
        tick();
    endtask

    task automatic test_partial();
        load_flags(4'b1001);
        ValidE = 1; Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b0110;
        tick();
        n_run++;
        if (Flags !== 4'b0101) begin
            n_fail++;
            $display("FAIL partial_nz got=%b exp=0101", Flags);
        end
        idle();
        ValidE = 1; FlagW = 2'b01; ALUFlags = 4'b1110;
        tick();
        n_run++;
        if (Flags !== 4'b0110) begin
            n_fail++;
            $display("FAIL partial_cv got=%b exp=0110", Flags);
        end
        idle();
    endtask

    task automatic test_fail_cond();
        load_flags(4'b0100);
        ValidE = 1; Cond = 4'b0001; RegW = 1; MemW = 1; PCS = 1;
        FlagW = 2'b11; ALUFlags = 4'b1000;
        #1;
        n_run++;
        if ({CondEx, PCSrcE} !== 2'b00) begin
            n_fail++;
            $display("FAIL ne_condex got=%b exp=00", {CondEx, PCSrcE});
        end
        tick();
        n_run++;
        if ({PCSrcM, RegWriteM, MemWriteM} !== 3'b000) begin
            n_fail++;
            $display("FAIL ne_m got=%b exp=000", {PCSrcM, RegWriteM, MemWriteM});
        end
        n_run++;
        if (Flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL ne_flags got=%b exp=0100", Flags);
        end
        idle();
    endtask

    task automatic test_stall_flush();
        load_flags(4'b0010);
        ValidE = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1000;
        RegW = 1; MemW = 1; StallE = 1;
        #1;
        n_run++;
        if (CondEx !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_condex got=%b exp=1", CondEx);
        end
        tick();
        n_run++;
        if ({Flags, RegWriteM, MemWriteM} !== 6'b0010_00) begin
            n_fail++;
            $display("FAIL stall_hold got=%b exp=001000", {Flags, RegWriteM, MemWriteM});
        end
        StallE = 0; FlushE = 1; PCS = 1;
        #1;
        n_run++;
        if (PCSrcE !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pcsrce got=%b exp=0", PCSrcE);
        end
        tick();
        n_run++;
        if ({Flags, PCSrcM, RegWriteM, MemWriteM} !== 7'b0010_000) begin
            n_fail++;
            $display("FAIL flush_hold got=%b exp=0010000",
                     {Flags, PCSrcM, RegWriteM, MemWriteM});
        end
        StallE = 1; FlushE = 1;
        tick();
        n_run++;
        if ({Flags, RegWriteM} !== 5'b0010_0) begin
            n_fail++;
            $display("FAIL stall_flush got=%b exp=00100", {Flags, RegWriteM});
        end
        StallE = 0; FlushE = 0;
        tick();
        n_run++;
        if ({Flags, PCSrcM, RegWriteM, MemWriteM} !== 7'b1000_111) begin
            n_fail++;
            $display("FAIL release got=%b exp=1000111",
                     {Flags, PCSrcM, RegWriteM, MemWriteM});
        end
        idle();
    endtask

    task automatic test_carry();
        load_flags(4'b0000);
        ValidE = 1; FlagW = 2'b01; ALUFlags = 4'b0010;
        #1;
        n_run++;
        if (C_Flag !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_old got=%b exp=0", C_Flag);
        end
        tick();
        n_run++;
        if (C_Flag !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_new got=%b exp=1", C_Flag);
        end
        idle();
        PCS = 1; ValidE = 0;
        #1;
        n_run++;
        if (PCSrcE !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_pcsrce got=%b exp=0", PCSrcE);
        end
        idle();
    endtask

    task automatic test_sweep();
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c);
                #1;
                n_run++;
                if (CondEx !== exp_cond(4'(c), 4'(f))) begin
                    n_fail++;
                    $display("FAIL sweep cond=%b flags=%b got=%b exp=%b",
                             4'(c), 4'(f), CondEx, exp_cond(4'(c), 4'(f)));
                end
            end
        end
        load_flags(4'b1001);
        Cond = 4'b1010;
        #1;
        n_run++;
        if (CondEx !== 1'b1) begin
            n_fail++;
            $display("FAIL ge_1001 got=%b exp=1", CondEx);
        end
        Cond = 4'b1011;
        #1;
        n_run++;
        if (CondEx !== 1'b0) begin
            n_fail++;
            $display("FAIL lt_1001 got=%b exp=0", CondEx);
        end
        Cond = 4'b1100;
        #1;
        n_run++;
        if (CondEx !== 1'b1) begin
            n_fail++;
            $display("FAIL gt_1001 got=%b exp=1", CondEx);
        end
        idle();
    endtask

    initial begin
        idle();
        RESETn = 0;
        test_reset();
        test_cmp_beq();
        test_partial();
        test_fail_cond();
        test_stall_flush();
        test_carry();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
